fifo_flags: RTL and testbench

- Synchronous FIFO that owns the buffer storage and generates the full / almost_full / empty / almost_empty status consumed by the flow-control FSM.
- The FSM drives pausa/continuar from these flags; this block is the flag-producing side of that interface.
- It also reports overflow/underflow through a sticky error output.
- Single clock domain; sits between the producer (push side) and the consumer (pop side).

---
 rtl/fifo_flags_if.sv | 27 ++
 rtl/fifo_flags.sv | 45 ++++
 tb/tb_fifo_flags.sv | 114 +++++++++++
 3 files changed

// File: rtl/fifo_flags_if.sv
// fifo_flags_if: push/pop data bus, thresholds and status flags between producer/consumer and the fifo
interface fifo_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH:0]   umbral_af;
  logic [ADDR_WIDTH:0]   umbral_ae;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic                  almost_empty;
  logic                  error;
  logic [ADDR_WIDTH:0]   count;
  modport master (
    output push, pop, data_in, umbral_af, umbral_ae,
    input  data_out, valid_out, full, almost_full, empty, almost_empty, error, count
  );
  modport slave (
    input  push, pop, data_in, umbral_af, umbral_ae,
    output data_out, valid_out, full, almost_full, empty, almost_empty, error, count
  );
endinterface

// File: rtl/fifo_flags.sv
// fifo_flags: synchronous fifo with occupancy-derived status flags and sticky overflow/underflow error
module fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input logic         clk,
  input logic         reset,
  fifo_flags_if.slave f
);
  localparam logic [ADDR_WIDTH:0] depth = {1'b1, {ADDR_WIDTH{1'b0}}};
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  we, re, bad;
  // flags depend only on registered count and the live thresholds
  assign f.full         = cnt == depth;
  assign f.empty        = cnt == '0;
  assign f.almost_full  = (f.umbral_af != '0) && (cnt >= f.umbral_af);
  assign f.almost_empty = cnt <= f.umbral_ae;
  assign f.count        = cnt;
  // a pop frees a slot on full, so push+pop on full is legal
  assign we  = f.push & (~f.full | f.pop);
  assign re  = f.pop & ~f.empty;
  assign bad = (f.push & f.full & ~f.pop) | (f.pop & f.empty);
  always_ff @(posedge clk)
    if (we && !reset) mem[wr_ptr] <= f.data_in;
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      f.data_out  <= '0;
      f.valid_out <= 1'b0;
      f.error     <= 1'b0;
    end else begin
      if (we) wr_ptr <= wr_ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      if (re) begin
        rd_ptr     <= rd_ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        f.data_out <= mem[rd_ptr];
      end
      f.valid_out <= re;
      cnt         <= cnt + {{ADDR_WIDTH{1'b0}}, we} - {{ADDR_WIDTH{1'b0}}, re};
      if (bad) f.error <= 1'b1;
    end
endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: directed vectors with hand-computed expectations for fifo_flags
module tb_fifo_flags;
  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;
  fifo_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) f ();
  fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (.clk(clk), .reset(reset), .f(f));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic pu, input logic po, input logic [7:0] d);
    f.push = pu; f.pop = po; f.data_in = d;
  endtask
  task automatic do_reset();
    reset = 1'b1; drive(0, 0, 8'h00); cyc(); reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1; drive(0, 0, 8'h00); f.umbral_af = 4'd6; f.umbral_ae = 4'd2;
    cyc(2); reset = 1'b0;
    check("rst_count", f.count, 0);
    check("rst_empty", f.empty, 1);
    check("rst_ae", f.almost_empty, 1);
    check("rst_full", f.full, 0);
    check("rst_af", f.almost_full, 0);
    check("rst_error", f.error, 0);
    check("rst_valid", f.valid_out, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 8'h10 + 8'(i)); cyc();
      check("fill_count", f.count, i + 1);
      check("fill_ae", f.almost_empty, (i + 1) <= 2);
      check("fill_af", f.almost_full, (i + 1) >= 6);
      check("fill_full", f.full, i == 7);
    end
    check("fill_error", f.error, 0);
    f.umbral_af = 4'd0; #1;
    check("af_disabled", f.almost_full, 0);
    f.umbral_af = 4'd9; f.umbral_ae = 4'd9; #1;
    check("af_over_depth", f.almost_full, 0);
    check("ae_over_depth", f.almost_empty, 1);
    f.umbral_af = 4'd6; f.umbral_ae = 4'd2;
    drive(1, 0, 8'hAA); cyc();
    check("ovf_count", f.count, 8);
    check("ovf_full", f.full, 1);
    check("ovf_error", f.error, 1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 8'h00); cyc();
      check("drain_valid", f.valid_out, 1);
      check("drain_data", f.data_out, 8'h10 + i);
      check("drain_count", f.count, 7 - i);
    end
    drive(0, 0, 8'h00); cyc();
    check("drain_idle_valid", f.valid_out, 0);
    check("drain_hold", f.data_out, 8'h17);
    check("drain_empty", f.empty, 1);
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1, 0, 8'h20 + 8'(i)); cyc(); end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 8'h00); cyc();
      check("wrap_a_data", f.data_out, 8'h20 + i);
    end
    for (int i = 0; i < 8; i++) begin drive(1, 0, 8'h30 + 8'(i)); cyc(); end
    check("wrap_full_count", f.count, 8);
    check("wrap_full", f.full, 1);
    drive(1, 1, 8'h40); cyc();
    check("pp_full_count", f.count, 8);
    check("pp_full_flag", f.full, 1);
    check("pp_full_error", f.error, 0);
    check("pp_full_data", f.data_out, 8'h30);
    check("pp_full_valid", f.valid_out, 1);
    for (int i = 1; i < 9; i++) begin
      drive(0, 1, 8'h00); cyc();
      check("wrap_b_data", f.data_out, i < 8 ? 8'h30 + i : 8'h40);
    end
    check("wrap_b_empty", f.empty, 1);
    check("wrap_b_error", f.error, 0);
    do_reset();
    drive(0, 1, 8'h00); cyc();
    check("unf_valid", f.valid_out, 0);
    check("unf_error", f.error, 1);
    check("unf_count", f.count, 0);
    drive(1, 1, 8'h55); cyc();
    check("unf_pp_count", f.count, 1);
    check("unf_pp_valid", f.valid_out, 0);
    drive(0, 1, 8'h00); cyc();
    check("unf_pop_valid", f.valid_out, 1);
    check("unf_pop_data", f.data_out, 8'h55);
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1, 0, 8'h60 + 8'(i)); cyc(); end
    check("mid_count", f.count, 5);
    reset = 1'b1; drive(1, 1, 8'h99); cyc(); reset = 1'b0;
    drive(0, 0, 8'h00);
    check("mid_rst_count", f.count, 0);
    check("mid_rst_empty", f.empty, 1);
    check("mid_rst_valid", f.valid_out, 0);
    check("mid_rst_error", f.error, 0);
    drive(1, 0, 8'h77); cyc();
    drive(0, 1, 8'h00); cyc();
    check("mid_data", f.data_out, 8'h77);
    check("mid_valid", f.valid_out, 1);
    drive(0, 0, 8'h00); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
